// File: rtl/ram_port_arbiter.sv
// Shares the single-port instruction/data RAM between fetch and load/store, round-robin on contention.
// Latency: grant and RAM command in the request cycle; read response/err one cycle later.
// Backpressure: a requester holds req/addr/data until gnt; at most one gnt per cycle.
module ram_port_arbiter #(
   parameter int DEPTH       = 32,
   parameter bit FETCH_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [7:0]  ls_addr,
   input  logic [7:0]  ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        ram_we,
   output logic [7:0]  ram_wr_addr,
   output logic [7:0]  ram_wdata,
   output logic [31:0] ram_rd_addr,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LS    = 2'd2
   } owner_t;

   owner_t      owner_q;      // who issued the read the RAM is answering this cycle
   logic        rr_fetch_q;   // 1: fetch wins the next contention
   logic [31:0] rd_addr_q;    // last read address presented, held while idle
   logic        if_rvalid_q;
   logic        ls_rvalid_q;
   logic        if_err_q;
   logic        ls_err_q;

   logic        if_oor;
   logic        ls_oor;
   logic        if_rd_ok;
   logic        ls_rd_ok;

   // Range check and arbitration; everything is gated off while reset is asserted.
   always_comb begin
      if_oor   = (if_addr >= 32'(DEPTH));
      ls_oor   = ({24'd0, ls_addr} >= 32'(DEPTH));
      if_gnt   = rst_n & if_req & (~ls_req | rr_fetch_q);
      ls_gnt   = rst_n & ls_req & (~if_req | ~rr_fetch_q);
      if_rd_ok = if_gnt & ~if_oor;
      ls_rd_ok = ls_gnt & ~ls_we & ~ls_oor;
   end

   // RAM command: out-of-range requests are granted but never reach the RAM.
   always_comb begin
      ram_we      = ls_gnt & ls_we & ~ls_oor;
      ram_wr_addr = ls_addr;
      ram_wdata   = ls_wdata;
      ram_rd_addr = rd_addr_q;
      if (!rst_n) begin
         ram_rd_addr = 32'd0;
      end else if (if_rd_ok) begin
         ram_rd_addr = if_addr;
      end else if (ls_rd_ok) begin
         ram_rd_addr = {24'd0, ls_addr};
      end
   end

   // Response routing: RAM data goes only to the owner of the read; error reads return 0.
   always_comb begin
      if_rvalid = if_rvalid_q;
      ls_rvalid = ls_rvalid_q;
      if_err    = if_err_q;
      ls_err    = ls_err_q;
      if_rdata  = (if_rvalid_q && owner_q == OWN_FETCH) ? ram_rdata : 32'd0;
      ls_rdata  = (ls_rvalid_q && owner_q == OWN_LS)    ? ram_rdata : 32'd0;
   end

   // Pointer, read owner, held read address and registered response flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_fetch_q  <= FETCH_FIRST;
         owner_q     <= OWN_NONE;
         rd_addr_q   <= 32'd0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         ls_err_q    <= 1'b0;
      end else begin
         // Only a contended grant moves the pointer, and it moves to the loser.
         if (if_req && ls_req) begin
            rr_fetch_q <= ls_gnt;
         end
         if (if_rd_ok) begin
            owner_q <= OWN_FETCH;
         end else if (ls_rd_ok) begin
            owner_q <= OWN_LS;
         end else begin
            owner_q <= OWN_NONE;
         end
         if (if_rd_ok || ls_rd_ok) begin
            rd_addr_q <= ram_rd_addr;
         end
         // Fetch is always a read, so every fetch grant produces a response.
         if_rvalid_q <= if_gnt;
         ls_rvalid_q <= ls_gnt & ~ls_we;
         if_err_q    <= if_gnt & if_oor;
         ls_err_q    <= ls_gnt & ls_oor;
      end
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter in front of the single-port 32-word instruction/data RAM.
- The RAM does either one write or one read per clock, with 1-cycle read latency.
- Shares that port between instruction fetch (read-only) and the load/store unit (read or byte write).
- Round-robin fairness, address range checking, and routing of each read response back to the requester that issued it.

Parameters:
- DEPTH, 32: number of RAM words; legal addresses are 0..DEPTH-1.
- FETCH_FIRST, 1: which requester wins the first contention after reset (1 = fetch, 0 = load/store).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch word address (PC).
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid (registered).
- if_rdata  out  32  fetch read data.
- if_err  out  1  fetch address out of range (registered, 1-cycle pulse).
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = byte write, 0 = read.
- ls_addr  in  8  load/store word address.
- ls_wdata  in  8  write data; zero-extended in RAM.
- ls_gnt  out  1  load/store request accepted this cycle (combinational).
- ls_rvalid  out  1  load read data valid (registered).
- ls_rdata  out  32  load read data.
- ls_err  out  1  load/store address out of range (registered, 1-cycle pulse).
- ram_we  out  1  RAM write enable (combinational).
- ram_wr_addr  out  8  RAM write address (= ls_addr).
- ram_wdata  out  8  RAM write data (= ls_wdata).
- ram_rd_addr  out  32  RAM read address (muxed fetch/ls address).
- ram_rdata  in  32  RAM read data; valid 1 cycle after the read command.

Behaviour:
- Reset (async assert, synchronous release):
  - if_rvalid, ls_rvalid, if_err, ls_err = 0; response-owner register = NONE.
  - RR pointer = FETCH_FIRST.
  - Combinational outputs gated while rst_n=0: if_gnt = ls_gnt = ram_we = 0; ram_rd_addr = 0.
- Handshake: requester holds req and its address/data stable until gnt. gnt and the RAM command occur in the same cycle. The RAM captures the command at the next rising edge.
- Arbitration, per cycle:
  - Only one req: that requester is granted.
  - Both req: the requester named by the RR pointer is granted.
  - After any contended grant, the pointer flips to the loser. Uncontended grants leave the pointer unchanged.
  - At most one gnt per cycle.
- Range check, on the granted request:
  - Fetch: if_addr >= DEPTH.
  - Load/store: ls_addr >= DEPTH.
  - An out-of-range request is still granted, but no RAM command is issued (ram_we=0, read result discarded).
  - The matching err pulses the next cycle. A read also gets rvalid that cycle with rdata = 0.
- Write (ls granted, ls_we=1, in range):
  - ram_we=1, ram_wr_addr=ls_addr, ram_wdata=ls_wdata.
  - No rvalid response; gnt marks completion.
  - ram_rdata is not updated by the RAM during a write cycle and must not be forwarded.
- Read (granted, in range):
  - ram_we=0, ram_rd_addr = granted address (ls_addr zero-extended to 32 bits).
  - Owner register records FETCH or LS.
  - Next cycle, exactly one of if_rvalid/ls_rvalid = 1 with its rdata = ram_rdata.
- Response data outputs: if_rdata/ls_rdata = ram_rdata while the respective rvalid = 1, otherwise 0.
- Owner register: NONE -> FETCH | LS on a read grant, and NONE on any cycle with no read grant. Back-to-back reads give rvalid every cycle.
- Idle (no req): ram_we=0, ram_rd_addr holds its last value, no responses.
- Reset mid-read: the pending rvalid is dropped and never emitted after reset release.
- Read-after-write to the same address on consecutive grants returns the new data (RAM write precedes the next read).

Test Plan:
- Reset → all outputs 0. Release; if_req=1, if_addr=3 → if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata = RAM[3] (0 after init).
- ls write ls_addr=5, ls_wdata=8'hA7 granted → ram_we=1 for exactly one cycle. Then ls read of addr 5 → ls_rvalid=1, ls_rdata=32'h000000A7.
- if_req and ls_req held continuously for 6 cycles, FETCH_FIRST=1 → grant order F,L,F,L,F,L; each read response lands on the correct port one cycle after its grant.
- ls write ls_addr=8'd40 → ls_gnt=1, ram_we=0, ls_err=1 next cycle, RAM unchanged. if_addr=32'd100 → if_err=1, if_rvalid=1, if_rdata=0.
- Fetch read granted, rst_n pulsed low mid-cycle before the next edge → no if_rvalid ever appears; RR pointer back to fetch.
- Write addr 7 = 8'h3C, then fetch read addr 7 on the next cycle → if_rdata=32'h0000003C.
